// File: rtl/fetch_split_buf.sv
// Fetch split buffer: accepts IN_BYTES instruction bytes per beat into a
// circular byte FIFO and presents one complete Y86-style instruction at the
// head, decoded combinationally, together with its pc and valP.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data  byte-beat input (bits [7:0] earliest byte)
//   out_valid/out_ready        head instruction handshake
//   icode, ifun, rA, rB, valC  decoded head instruction fields
//   pc, valP                   head address and next sequential address
//   instr_invalid, halted      head icode > B; block stopped
module fetch_split_buf #(
  parameter int unsigned IN_BYTES     = 2,
  parameter int unsigned BUF_BYTES    = 16,
  parameter logic [63:0] PC_INIT      = 64'h0,
  parameter bit          STOP_ON_HALT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*IN_BYTES-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            icode,
  output logic [3:0]            ifun,
  output logic [3:0]            rA,
  output logic [3:0]            rB,
  output logic [63:0]           valC,
  output logic [63:0]           pc,
  output logic [63:0]           valP,
  output logic                  instr_invalid,
  output logic                  halted
);

  localparam int unsigned PTR_W  = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
  localparam int unsigned CNT_W  = $clog2(BUF_BYTES + 1);
  localparam int unsigned HEAD_N = 10;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

  state_e           state_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      pc_q;
  logic [7:0]       buf_q [BUF_BYTES];

  logic [7:0] head_b [HEAD_N];
  logic [3:0] head_ic;
  logic [3:0] head_len;
  logic       push, pop, stop_c;

  // Pointer advance modulo BUF_BYTES; k never exceeds BUF_BYTES so one
  // conditional subtract is enough.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= BUF_BYTES) s = s - BUF_BYTES;
    return PTR_W'(s);
  endfunction

  // Instruction length in bytes from icode; unknown codes are 1 byte.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
      4'h7, 4'h8:             return 4'd9;
      4'h3, 4'h4, 4'h5:       return 4'd10;
      default:                return 4'd1;
    endcase
  endfunction

  // Gather the ten bytes starting at the read pointer.
  always_comb begin : head_fetch
    for (int unsigned k = 0; k < HEAD_N; k++) begin
      head_b[k] = buf_q[wrap_add(rd_ptr_q, k)];
    end
  end

  // Head decode and handshake generation; fields are neutral while invalid.
  always_comb begin : decode
    head_ic       = head_b[0][7:4];
    head_len      = instr_len(head_ic);
    out_valid     = (state_q == ST_RUN) && (count_q != '0) &&
                    (32'(count_q) >= 32'(head_len));
    in_ready      = (state_q == ST_RUN) &&
                    ((BUF_BYTES - 32'(count_q)) >= IN_BYTES);
    icode         = 4'h0;
    ifun          = 4'h0;
    rA            = 4'hF;
    rB            = 4'hF;
    valC          = 64'h0;
    instr_invalid = 1'b0;
    valP          = pc_q;
    if (out_valid) begin
      icode         = head_ic;
      ifun          = head_b[0][3:0];
      instr_invalid = (head_ic > 4'hB);
      valP          = pc_q + 64'(head_len);
      case (head_ic)
        4'h2, 4'h6, 4'hA, 4'hB: begin
          rA = head_b[1][7:4];
          rB = head_b[1][3:0];
        end
        4'h3, 4'h4, 4'h5: begin
          rA   = head_b[1][7:4];
          rB   = head_b[1][3:0];
          valC = {head_b[9], head_b[8], head_b[7], head_b[6],
                  head_b[5], head_b[4], head_b[3], head_b[2]};
        end
        4'h7, 4'h8: begin
          valC = {head_b[8], head_b[7], head_b[6], head_b[5],
                  head_b[4], head_b[3], head_b[2], head_b[1]};
        end
        default: ;
      endcase
    end
  end

  // Transfer qualifiers and next occupancy (push and pop may coincide).
  always_comb begin : next_count
    push    = in_valid && in_ready;
    pop     = out_valid && out_ready;
    stop_c  = pop && STOP_ON_HALT && ((head_ic == 4'h0) || (head_ic > 4'hB));
    count_d = CNT_W'(32'(count_q) + (push ? IN_BYTES : 32'd0)
                     - (pop ? 32'(head_len) : 32'd0));
  end

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALTED);

  // Control state: pointers, occupancy, pc and RUN/HALTED.
  always_ff @(posedge clk) begin : ctrl
    if (reset) begin
      state_q  <= ST_RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= PC_INIT;
    end else if (state_q == ST_RUN) begin
      if (push) wr_ptr_q <= wrap_add(wr_ptr_q, IN_BYTES);
      if (pop) begin
        rd_ptr_q <= wrap_add(rd_ptr_q, 32'(head_len));
        pc_q     <= valP;
      end
      // Halting drops whatever is still buffered.
      if (stop_c) begin
        state_q <= ST_HALTED;
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end
  end

  // Byte storage; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin : buf_write
    if (push && !reset) begin
      for (int unsigned j = 0; j < IN_BYTES; j++) begin
        buf_q[wrap_add(wr_ptr_q, j)] <= in_data[8*j +: 8];
      end
    end
  end

endmodule

// File: tb/tb_fetch_split_buf.sv
// Directed bench for fetch_split_buf: dut_a uses defaults (halt stops),
// dut_b shares its inputs with STOP_ON_HALT=0 and PC_INIT at the top of the
// 64-bit range so the halt-continue case also exercises pc wrap.
module tb_fetch_split_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;

  logic        a_in_ready, a_out_valid, a_invalid, a_halted;
  logic [3:0]  a_icode, a_ifun, a_ra, a_rb;
  logic [63:0] a_valc, a_pc, a_valp;
  logic        b_in_ready, b_out_valid, b_invalid, b_halted;
  logic [3:0]  b_icode, b_ifun, b_ra, b_rb;
  logic [63:0] b_valc, b_pc, b_valp;

  int errors = 0;
  int checks = 0;

  fetch_split_buf #(.IN_BYTES(2), .BUF_BYTES(16), .PC_INIT(64'h0),
                    .STOP_ON_HALT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .icode(a_icode), .ifun(a_ifun), .rA(a_ra), .rB(a_rb), .valC(a_valc),
    .pc(a_pc), .valP(a_valp), .instr_invalid(a_invalid), .halted(a_halted));

  fetch_split_buf #(.IN_BYTES(2), .BUF_BYTES(16),
                    .PC_INIT(64'hFFFF_FFFF_FFFF_FFFF),
                    .STOP_ON_HALT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .icode(b_icode), .ifun(b_ifun), .rA(b_ra), .rB(b_rb), .valC(b_valc),
    .pc(b_pc), .valP(b_valp), .instr_invalid(b_invalid), .halted(b_halted));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    chk("push_in_ready", 64'(a_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic head_a(input string tag, input logic [3:0] ic,
                        input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc,
                        input logic [63:0] p, input logic [63:0] vp);
    chk({tag, ".out_valid"}, 64'(a_out_valid), 64'd1);
    chk({tag, ".icode"}, 64'(a_icode), 64'(ic));
    chk({tag, ".ifun"}, 64'(a_ifun), 64'(fn));
    chk({tag, ".rA"}, 64'(a_ra), 64'(ra));
    chk({tag, ".rB"}, 64'(a_rb), 64'(rb));
    chk({tag, ".valC"}, a_valc, vc);
    chk({tag, ".pc"}, a_pc, p);
    chk({tag, ".valP"}, a_valp, vp);
    chk({tag, ".invalid"}, 64'(a_invalid), 64'(ic > 4'hB));
  endtask

  function automatic logic [15:0] opq_beat(input int unsigned i);
    logic [7:0] rr;
    rr = {4'(i), 4'(15 - i)};
    return {rr, 8'h60};
  endfunction

  initial begin
    @(negedge clk);
    do_reset();
    // Reset state.
    chk("rst.out_valid", 64'(a_out_valid), 64'd0);
    chk("rst.halted", 64'(a_halted), 64'd0);
    chk("rst.in_ready", 64'(a_in_ready), 64'd1);
    chk("rst.pc", a_pc, 64'h0);
    chk("rst.valP", a_valp, 64'h0);
    chk("rst.rA", 64'(a_ra), 64'hF);
    chk("rst.b_pc", b_pc, 64'hFFFF_FFFF_FFFF_FFFF);

    // irmovq-class 10-byte instruction: 30 F2 0A 00 ...
    push(16'hF230);
    push(16'h000A);
    push(16'h0000);
    push(16'h0000);
    chk("irm.partial_out_valid", 64'(a_out_valid), 64'd0);
    chk("irm.partial_icode", 64'(a_icode), 64'd0);
    push(16'h0000);
    head_a("irm", 4'h3, 4'h0, 4'hF, 4'h2, 64'h0A, 64'd0, 64'd10);
    pop();
    chk("irm.pc_after", a_pc, 64'd10);
    chk("irm.empty", 64'(a_out_valid), 64'd0);

    // nop, OPq 1,2, ret
    do_reset();
    push(16'h6010);
    push(16'h9012);
    head_a("seq.nop", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd0, 64'd1);
    pop();
    head_a("seq.opq", 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'd1, 64'd3);
    pop();
    head_a("seq.ret", 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'd3, 64'd4);
    pop();
    chk("seq.empty", 64'(a_out_valid), 64'd0);
    chk("seq.pc", a_pc, 64'd4);

    // Invalid head byte F0 halts the default instance.
    push(16'h10F0);
    head_a("inv", 4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 64'd4, 64'd5);
    pop();
    chk("inv.halted", 64'(a_halted), 64'd1);
    chk("inv.pc", a_pc, 64'd5);
    chk("inv.in_ready", 64'(a_in_ready), 64'd0);

    // Backpressure, full buffer, simultaneous push/pop and pointer wrap.
    do_reset();
    for (int unsigned i = 0; i < 8; i++) push(opq_beat(i));
    chk("bp.full_in_ready", 64'(a_in_ready), 64'd0);
    head_a("bp.i0", 4'h6, 4'h0, 4'h0, 4'hF, 64'h0, 64'd0, 64'd2);
    pop();
    chk("bp.free2_in_ready", 64'(a_in_ready), 64'd1);
    head_a("bp.i1", 4'h6, 4'h0, 4'h1, 4'hE, 64'h0, 64'd2, 64'd4);
    in_valid  = 1'b1;
    in_data   = opq_beat(8);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp.same_edge_in_ready", 64'(a_in_ready), 64'd1);
    push(opq_beat(9));
    chk("bp.refull_in_ready", 64'(a_in_ready), 64'd0);
    for (int unsigned i = 2; i < 10; i++) begin
      head_a("bp.drain", 4'h6, 4'h0, 4'(i), 4'(15 - i), 64'h0,
             64'(2 * i), 64'(2 * i + 2));
      pop();
    end
    chk("bp.empty", 64'(a_out_valid), 64'd0);
    chk("bp.pc", a_pc, 64'd20);

    // Halt then nop: dut_a stops, dut_b continues with pc wrapping to 0.
    do_reset();
    push(16'h1000);
    head_a("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd0, 64'd1);
    chk("halt.b_valP_wrap", b_valp, 64'h0);
    pop();
    chk("halt.a_halted", 64'(a_halted), 64'd1);
    chk("halt.a_in_ready", 64'(a_in_ready), 64'd0);
    chk("halt.a_out_valid", 64'(a_out_valid), 64'd0);
    chk("halt.a_pc", a_pc, 64'd1);
    chk("halt.b_halted", 64'(b_halted), 64'd0);
    chk("halt.b_out_valid", 64'(b_out_valid), 64'd1);
    chk("halt.b_icode", 64'(b_icode), 64'd1);
    chk("halt.b_pc", b_pc, 64'd0);
    chk("halt.b_valP", b_valp, 64'd1);
    pop();
    chk("halt.b_pc_after_nop", b_pc, 64'd1);
    chk("halt.a_pc_frozen", a_pc, 64'd1);

    // Reset with a partial call buffered (7 of 9 bytes after a nop).
    do_reset();
    push(16'h8010);
    push(16'h2211);
    push(16'h4433);
    push(16'h6655);
    pop();
    chk("part.out_valid", 64'(a_out_valid), 64'd0);
    chk("part.pc", a_pc, 64'd1);
    do_reset();
    chk("part.rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("part.rst_pc", a_pc, 64'd0);
    chk("part.rst_in_ready", 64'(a_in_ready), 64'd1);
    push(16'h8010);
    push(16'h0201);
    push(16'h0403);
    push(16'h0605);
    chk("call.partial", 64'(a_out_valid), 64'd1);
    pop();
    chk("call.wait", 64'(a_out_valid), 64'd0);
    push(16'h0807);
    head_a("call", 4'h8, 4'h0, 4'hF, 4'hF, 64'h0807_0605_0403_0201,
           64'd1, 64'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_split_buf.md
FETCH_SPLIT_BUF -- requirements
Module: fetch_split_buf

Interface
REQ-001 Parameter IN_BYTES, default 2, instruction bytes accepted per input beat; legal values 1, 2, 4.
REQ-002 Parameter BUF_BYTES, default 16, byte-buffer depth; must be at least 10 + IN_BYTES.
REQ-003 Parameter PC_INIT, default 64'h0, PC of the first byte after reset.
REQ-004 Parameter STOP_ON_HALT, default 1; 1 = halt/invalid instruction stops the block, 0 = decode continues.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  in_data holds IN_BYTES valid instruction bytes.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  8*IN_BYTES  bits [7:0] = earliest byte in program order.
REQ-010 out_valid  output  1  complete instruction present at buffer head.
REQ-011 out_ready  input  1  consumer takes the instruction.
REQ-012 icode, ifun  output  4 each  high and low nibble of head byte 0.
REQ-013 rA, rB  output  4 each  high and low nibble of byte 1; 4'hF when the instruction has no register byte.
REQ-014 valC  output  64  little-endian constant; 0 when absent.
REQ-015 pc, valP  output  64 each  address of the head instruction; pc + instruction length.
REQ-016 instr_invalid  output  1  head icode > 4'hB.
REQ-017 halted  output  1  block is in HALTED state.

Function
REQ-018 Length by icode: 0,1,9 -> 1 byte; 2,6,A,B -> 2 bytes; 7,8 -> 9 bytes; 3,4,5 -> 10 bytes; C..F -> 1 byte.
REQ-019 valC source: icode 7,8 -> bytes 1..8; icode 3,4,5 -> bytes 2..9.
REQ-020 Register-byte source: rA/rB from byte 1 only for icodes 2,3,4,5,6,A,B.
REQ-021 Buffer is a circular byte FIFO with occupancy count 0..BUF_BYTES; read/write pointers wrap modulo BUF_BYTES.
REQ-022 Beat accept: in_valid && in_ready at an edge appends IN_BYTES bytes in order.
REQ-023 in_ready = state RUN && (BUF_BYTES - occupancy) >= IN_BYTES, computed from pre-pop occupancy; no combinational path from out_ready.
REQ-024 out_valid = state RUN && occupancy >= 1 && occupancy >= length(head icode); outputs decode buffer head combinationally.
REQ-025 Pop: out_valid && out_ready at an edge removes length bytes and sets pc <= valP.
REQ-026 Simultaneous push and pop in one edge updates occupancy by IN_BYTES - length.
REQ-027 Latency: a complete instruction whose last byte is accepted at edge N has out_valid high in the cycle after N.
REQ-028 While out_valid is 0: icode 0, ifun 0, rA F, rB F, valC 0, instr_invalid 0, valP = pc.
REQ-029 States are RUN and HALTED; RUN -> HALTED on a pop of icode 0 or icode > B when STOP_ON_HALT = 1; HALTED is left only by reset.
REQ-030 In HALTED: in_ready 0, out_valid 0, halted 1, pc frozen at the halting instruction's valP, and remaining buffer bytes discarded.
REQ-031 With STOP_ON_HALT = 0, halt and invalid instructions pop as 1-byte instructions and the block stays in RUN.
REQ-032 pc arithmetic is 64-bit modulo 2^64; valP wraps silently.

Reset
REQ-033 On reset: occupancy 0, pointers 0, pc = PC_INIT, state RUN, out_valid 0, halted 0, and in_ready 1 in the following cycle.
REQ-034 Reset has priority over a simultaneous push or pop; a partially buffered instruction is discarded.

Verification (IN_BYTES=2, PC_INIT=0 unless stated)
REQ-035 Beats 30F2, 0A00, 0000, 0000, 0000, out_ready=1 -> after 5th beat: icode 3, ifun 0, rA F, rB 2, valC 0x0A, pc 0, valP 10, and the pop then sets pc=10.
REQ-036 Byte stream 10 60 12 90 -> instructions pop in order: nop (pc0, valP1), OPq rA1 rB2 (pc1, valP3), ret (pc3, valP4).
REQ-037 Hold out_ready=0 and stream bytes -> in_ready drops when free < 2; no byte is lost or duplicated after release, and the FIFO wraps past index 15 correctly.
REQ-038 Stream 00 10 with STOP_ON_HALT=1 -> halt pops and halted=1, in_ready=0, out_valid=0, pc=1; with STOP_ON_HALT=0 the nop then pops at pc1.
REQ-039 Head byte F0 -> instr_invalid 1, length 1, valP = pc+1.
REQ-040 Assert reset with 7 of 9 bytes of a call (80 ...) buffered -> out_valid 0 and pc = PC_INIT, and the next stream decodes from a clean buffer.
